jtvigil_bank_arb: RTL and testbench

//  Shares one SDRAM bank read port between NCLI 8-bit ROM clients (main CPU, sound CPU, PCM) in jtvigil_sdram.

---
 rtl/jtvigil_bank_arb_pkg.sv | 14 +
 rtl/jtvigil_bank_cache.sv | 64 ++++++
 rtl/jtvigil_bank_arb.sv | 136 +++++++++++++
 tb/tb_jtvigil_bank_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_bank_arb_pkg.sv
// Shared widths and address helper for the jtvigil SDRAM bank read arbiter.
package jtvigil_bank_arb_pkg;

  localparam int unsigned BA_AW = 22;
  localparam int unsigned DW    = 16;
  localparam int unsigned GW    = 2;

  // Bank word address = client offset + client word address, wrapping at 2^22.
  function automatic logic [BA_AW-1:0] ba_word_addr(input logic [BA_AW-1:0] offs,
                                                    input logic [BA_AW-1:0] waddr);
    return offs + waddr;
  endfunction

endpackage

// File: rtl/jtvigil_bank_cache.sv
// One-word read cache for a single 8-bit ROM client of the SDRAM bank arbiter.
module jtvigil_bank_cache
  import jtvigil_bank_arb_pkg::*;
#(
  parameter int unsigned AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-2:0] fill_tag,
  input  logic [DW-1:0] fill_word,
  output logic          miss_c,
  output logic          ok,
  output logic [7:0]    data
);

  logic          valid_q, valid_d;
  logic [AW-2:0] tag_q, tag_d;
  logic [DW-1:0] word_q, word_d;
  logic          ok_q, ok_d;
  logic [7:0]    data_q, data_d;
  logic          hit_c;

  // clr masks the hit in the same cycle so ok falls on the next edge
  assign hit_c  = cs & valid_q & ~clr & (tag_q == addr[AW-1:1]);
  assign miss_c = cs & ~hit_c;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    if (fill) begin
      tag_d  = fill_tag;
      word_d = fill_word;
    end
    if (clr)       valid_d = 1'b0;
    else if (fill) valid_d = 1'b1;
    ok_d   = hit_c;
    data_d = addr[0] ? word_q[15:8] : word_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
      ok_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
      ok_q    <= ok_d;
      data_q  <= data_d;
    end
  end

  assign ok   = ok_q;
  assign data = data_q;

endmodule

// File: rtl/jtvigil_bank_arb.sv
// Fixed-priority arbiter sharing one SDRAM bank read port between cached 8-bit ROM clients.
module jtvigil_bank_arb
  import jtvigil_bank_arb_pkg::*;
#(
  parameter int unsigned         NCLI = 3,
  parameter int unsigned         AW   = 18,
  parameter logic [22*NCLI-1:0]  OFFS = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [NCLI-1:0]    cli_cs,
  input  logic [NCLI*AW-1:0] cli_addr,
  output logic [NCLI-1:0]    cli_ok,
  output logic [NCLI*8-1:0]  cli_data,
  output logic [BA_AW-1:0]   ba_addr,
  output logic               ba_rd,
  input  logic               ba_ack,
  input  logic               ba_rdy,
  input  logic [DW-1:0]      data_read,
  output logic               busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic [AW-2:0]    tag_q, tag_d;
  logic             ba_rd_q, ba_rd_d;
  logic [BA_AW-1:0] ba_addr_q, ba_addr_d;
  logic             busy_q, busy_d;
  logic [NCLI-1:0]  miss_c;
  logic             fill_c;
  logic             found_c;
  logic [GW-1:0]    pick_c;
  logic [AW-2:0]    pick_tag_c;
  logic [BA_AW-1:0] pick_offs_c;

  genvar gi;
  generate
    for (gi = 0; gi < int'(NCLI); gi++) begin : g_cache
      jtvigil_bank_cache #(.AW(AW)) u_cache (
        .clk       (clk),
        .rst       (rst),
        .clr       (downloading),
        .cs        (cli_cs[gi]),
        .addr      (cli_addr[AW*gi +: AW]),
        .fill      (fill_c && (gnt_q == GW'(gi))),
        .fill_tag  (tag_q),
        .fill_word (data_read),
        .miss_c    (miss_c[gi]),
        .ok        (cli_ok[gi]),
        .data      (cli_data[8*gi +: 8])
      );
    end
  endgenerate

  // Lowest-index missing client wins
  always_comb begin
    found_c     = 1'b0;
    pick_c      = '0;
    pick_tag_c  = '0;
    pick_offs_c = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (miss_c[i] && !found_c) begin
        found_c     = 1'b1;
        pick_c      = GW'(i);
        pick_tag_c  = cli_addr[AW*i+1 +: AW-1];
        pick_offs_c = OFFS[BA_AW*i +: BA_AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      tag_q     <= '0;
      ba_rd_q   <= 1'b0;
      ba_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      tag_q     <= tag_d;
      ba_rd_q   <= ba_rd_d;
      ba_addr_q <= ba_addr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!downloading && found_c) state_d = REQ;
      REQ:     if (ba_ack) state_d = ba_rdy ? IDLE : WAIT;
      WAIT:    if (ba_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching and fill strobe; ack+rdy together in REQ fills immediately
  always_comb begin
    gnt_d     = gnt_q;
    tag_d     = tag_q;
    ba_rd_d   = ba_rd_q;
    ba_addr_d = ba_addr_q;
    fill_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!downloading && found_c) begin
          gnt_d     = pick_c;
          tag_d     = pick_tag_c;
          ba_addr_d = ba_word_addr(pick_offs_c, BA_AW'(pick_tag_c));
          ba_rd_d   = 1'b1;
        end
      end
      REQ: begin
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          fill_c  = ba_rdy;
        end
      end
      WAIT:    fill_c = ba_rdy;
      default: ba_rd_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ba_rd   = ba_rd_q;
  assign ba_addr = ba_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_jtvigil_bank_arb.sv
// Directed bench for jtvigil_bank_arb with a simple ack/rdy SDRAM responder.
module tb_jtvigil_bank_arb;

  localparam int unsigned NCLI = 3;
  localparam int unsigned AW   = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              downloading;
  logic [NCLI-1:0]   cli_cs;
  logic [NCLI*AW-1:0] cli_addr;
  logic [NCLI-1:0]   cli_ok;
  logic [NCLI*8-1:0] cli_data;
  logic [21:0]       ba_addr;
  logic              ba_rd;
  logic              ba_ack;
  logic              ba_rdy;
  logic [15:0]       data_read;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_dly = 2;
  int rdy_dly = 3;
  int m_st, m_cnt;
  logic [21:0] m_addr;

  jtvigil_bank_arb #(
    .NCLI(NCLI), .AW(AW),
    .OFFS({22'h3000, 22'h2000, 22'h1000})
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .cli_cs(cli_cs), .cli_addr(cli_addr), .cli_ok(cli_ok), .cli_data(cli_data),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .data_read(data_read), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    if (a == 22'h1008) return 16'hBEEF;
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    cli_addr[AW*i +: AW] = a;
  endtask

  // Step until ba_rd reaches level; returns the number of steps taken
  task automatic wait_rd(input string tag, input logic level, output int n);
    n = 0;
    while (ba_rd !== level && n < 30) begin
      step();
      n++;
    end
    if (ba_rd !== level) check_eq({tag, "_timeout"}, 32'(ba_rd), 32'(level));
  endtask

  task automatic wait_ok(input string tag, input int i);
    int n;
    n = 0;
    while (cli_ok[i] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check_eq(tag, 32'(cli_ok[i]), 32'd1);
  endtask

  task automatic step_watch(input int n, output logic rd_or);
    rd_or = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      rd_or = rd_or | ba_rd;
    end
  endtask

  // SDRAM responder: ack ack_dly cycles after ba_rd rises, rdy rdy_dly cycles after ack
  initial begin
    ba_ack = 1'b0; ba_rdy = 1'b0; data_read = '0;
    m_st = 0; m_cnt = 0; m_addr = '0;
    forever begin
      @(negedge clk);
      ba_ack = 1'b0;
      ba_rdy = 1'b0;
      if (rst) m_st = 0;
      else begin
        case (m_st)
          0: if (ba_rd) begin m_addr = ba_addr; m_cnt = 1; m_st = 1; end
          1: begin
            m_cnt++;
            if (m_cnt >= ack_dly) begin
              ba_ack = 1'b1;
              m_cnt  = 0;
              if (rdy_dly == 0) begin
                ba_rdy = 1'b1; data_read = mem_word(m_addr); m_st = 0;
              end else m_st = 2;
            end
          end
          default: begin
            m_cnt++;
            if (m_cnt >= rdy_dly) begin
              ba_rdy = 1'b1; data_read = mem_word(m_addr); m_st = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    int n;
    logic rd_or;
    logic ok_acc;
    rst = 1'b1; downloading = 1'b0; cli_cs = '0; cli_addr = '0;
    repeat (3) step();
    check_eq("rst_ok",   32'(cli_ok),   32'd0);
    check_eq("rst_data", 32'(cli_data), 32'd0);
    check_eq("rst_rd",   32'(ba_rd),    32'd0);
    check_eq("rst_addr", 32'(ba_addr),  32'd0);
    check_eq("rst_busy", 32'(busy),     32'd0);

    // 1) first miss of client 0
    rst = 1'b0;
    cli_cs = 3'b001;
    set_addr(0, 18'h00010);
    wait_rd("t1_rd", 1'b1, n);
    check_eq("t1_ba_addr", 32'(ba_addr), 32'h1008);
    check_eq("t1_busy",    32'(busy),    32'd1);
    wait_rd("t1_ack", 1'b0, n);
    check_eq("t1_rd_len", 32'(n), 32'd2);
    wait_ok("t1_ok", 0);
    check_eq("t1_data", 32'(cli_data[7:0]), 32'hEF);

    // 2) odd byte of the cached word
    set_addr(0, 18'h00011);
    step();
    check_eq("t2_ok",   32'(cli_ok[0]),     32'd1);
    check_eq("t2_data", 32'(cli_data[7:0]), 32'hBE);
    step_watch(4, rd_or);
    check_eq("t2_no_rd", 32'(rd_or),     32'd0);
    check_eq("t2_ok_hold", 32'(cli_ok[0]), 32'd1);

    // 3) clients 0 and 2 miss together
    set_addr(0, 18'h00100);
    set_addr(2, 18'h00031);
    cli_cs = 3'b101;
    wait_rd("t3_rd0", 1'b1, n);
    check_eq("t3_addr0", 32'(ba_addr), 32'h1080);
    wait_rd("t3_ack0", 1'b0, n);
    wait_rd("t3_rd2", 1'b1, n);
    check_eq("t3_gap",   32'(n),       32'd4);
    check_eq("t3_addr2", 32'(ba_addr), 32'h3018);
    wait_ok("t3_ok2", 2);
    check_eq("t3_data2", 32'(cli_data[23:16]), 32'h95);
    check_eq("t3_ok0",   32'(cli_ok[0]),       32'd1);
    check_eq("t3_data0", 32'(cli_data[7:0]),   32'h43);

    // 4) client 1 moves its address during WAIT
    cli_cs = 3'b111;
    set_addr(1, 18'h00200);
    wait_rd("t4_rd", 1'b1, n);
    check_eq("t4_addr_old", 32'(ba_addr), 32'h2100);
    wait_rd("t4_ack", 1'b0, n);
    set_addr(1, 18'h00400);
    ok_acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      ok_acc = ok_acc | cli_ok[1];
      if (ba_rd) break;
    end
    check_eq("t4_rd2",      32'(ba_rd),   32'd1);
    check_eq("t4_addr_new", 32'(ba_addr), 32'h2200);
    check_eq("t4_no_stale_ok", 32'(ok_acc), 32'd0);
    wait_ok("t4_ok", 1);
    check_eq("t4_data", 32'(cli_data[15:8]), 32'hC3);

    // 5) downloading rises during WAIT
    step();
    check_eq("t5_all_ok", 32'(cli_ok), 32'b111);
    set_addr(0, 18'h00020);
    wait_rd("t5_rd", 1'b1, n);
    check_eq("t5_addr", 32'(ba_addr), 32'h1010);
    wait_rd("t5_ack", 1'b0, n);
    downloading = 1'b1;
    step();
    check_eq("t5_ok_clr", 32'(cli_ok), 32'd0);
    step_watch(8, rd_or);
    check_eq("t5_no_rd", 32'(rd_or), 32'd0);
    check_eq("t5_idle",  32'(busy),  32'd0);
    cli_cs = 3'b001;
    downloading = 1'b0;
    wait_rd("t5_rd_again", 1'b1, n);
    check_eq("t5_addr_again", 32'(ba_addr), 32'h1010);
    wait_ok("t5_ok", 0);
    check_eq("t5_data", 32'(cli_data[7:0]), 32'hD3);

    // 6) reset while in REQ
    set_addr(0, 18'h00040);
    wait_rd("t6_rd", 1'b1, n);
    rst = 1'b1;
    step();
    check_eq("t6_rd_drop", 32'(ba_rd),  32'd0);
    check_eq("t6_ok",      32'(cli_ok), 32'd0);
    check_eq("t6_busy",    32'(busy),   32'd0);
    step();
    rst = 1'b0;
    wait_rd("t6_rd_again", 1'b1, n);
    check_eq("t6_addr", 32'(ba_addr), 32'h1020);
    wait_ok("t6_ok_again", 0);
    check_eq("t6_data", 32'(cli_data[7:0]), 32'hE3);

    // 7) ack and rdy in the same cycle
    rdy_dly = 0;
    set_addr(0, 18'h00080);
    wait_rd("t7_rd", 1'b1, n);
    check_eq("t7_addr", 32'(ba_addr), 32'h1040);
    wait_rd("t7_ack", 1'b0, n);
    check_eq("t7_rd_len", 32'(n), 32'd2);
    step();
    check_eq("t7_ok",   32'(cli_ok[0]),     32'd1);
    check_eq("t7_data", 32'(cli_data[7:0]), 32'h83);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
